// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the LED blink queue.
// Holds the FSM state encoding and the counter-width helper.
package led_blink_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } blink_state_e;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/led_blink_queue_if.sv
// Event-in / LED-out bundle of the blink queue.
// The event source (master) drives the strobes and sees the status.
interface led_blink_queue_if #(
    parameter int PEND_W = 4
);
    logic              i_pulse;
    logic              i_clr;
    logic              o_led;
    logic              o_busy;
    logic [PEND_W-1:0] o_pending;
    logic              o_overflow;

    modport master (
        output i_pulse, i_clr,
        input  o_led, o_busy, o_pending, o_overflow
    );

    modport slave (
        input  i_pulse, i_clr,
        output o_led, o_busy, o_pending, o_overflow
    );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// The synchronous clear restarts the count so each phase starts at a tick boundary.
module tick_gen
    import led_blink_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sclr,
    output logic o_tick
);
    localparam int            CW   = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;

    assign o_tick = (cnt_r == LAST);

    // Prescaler count: compare-and-clear, never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (i_sclr || o_tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end
endmodule

// File: rtl/led_blink_queue.sv
// Turns one-clock event pulses into visible ON/OFF LED blinks, queueing
// events that arrive mid-blink in a saturating pending counter.
module led_blink_queue
    import led_blink_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int ON_TICKS  = 100,
    parameter int OFF_TICKS = 100,
    parameter int PEND_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    led_blink_queue_if.slave  bus
);
    localparam int                MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int                PW        = cnt_width(MAX_TICKS);
    localparam logic [PW-1:0]     ON_LAST   = PW'(ON_TICKS - 1);
    localparam logic [PW-1:0]     OFF_LAST  = PW'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    blink_state_e      state_r, state_s;
    logic [PW-1:0]     phase_r, phase_s;
    logic [PEND_W-1:0] pend_r, pend_s;
    logic              ovf_r, ovf_s;
    logic              led_r, busy_r;
    logic              tick_s, sclr_s, pulse_s;

    // Prescaler restarts on every state change and is held clear while idle.
    assign sclr_s = (state_s != state_r) || (state_r == S_IDLE);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_sclr (sclr_s),
        .o_tick (tick_s)
    );

    // Next state, phase count, queue depth and overflow flag.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        pend_s  = pend_r;
        ovf_s   = ovf_r;
        // A clear while a blink runs swallows any same-cycle event.
        pulse_s = bus.i_pulse && !(bus.i_clr && (state_r != S_IDLE));
        case (state_r)
            S_IDLE: begin
                if (bus.i_pulse) begin
                    state_s = S_ON;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ON: begin
                if (tick_s && (phase_r == ON_LAST)) begin
                    state_s = S_GAP;
                    phase_s = '0;
                end else if (tick_s) begin
                    phase_s = phase_r + PW'(1);
                end else begin
                    phase_s = phase_r;
                end
                if (pulse_s && (pend_r == PEND_MAX)) begin
                    ovf_s = 1'b1;
                end else if (pulse_s) begin
                    pend_s = pend_r + PEND_W'(1);
                end else begin
                    pend_s = pend_r;
                end
            end
            S_GAP: begin
                if (tick_s && (phase_r == OFF_LAST)) begin
                    phase_s = '0;
                    if ((pend_r != '0) && !bus.i_clr) begin
                        // A same-cycle event replaces the one taken from the queue.
                        state_s = S_ON;
                        pend_s  = pulse_s ? pend_r : (pend_r - PEND_W'(1));
                    end else if (pulse_s) begin
                        state_s = S_ON;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    if (tick_s) begin
                        phase_s = phase_r + PW'(1);
                    end else begin
                        phase_s = phase_r;
                    end
                    if (pulse_s && (pend_r == PEND_MAX)) begin
                        ovf_s = 1'b1;
                    end else if (pulse_s) begin
                        pend_s = pend_r + PEND_W'(1);
                    end else begin
                        pend_s = pend_r;
                    end
                end
            end
            default: begin
                state_s = S_IDLE;
                phase_s = '0;
            end
        endcase
        if (bus.i_clr) begin
            pend_s = '0;
            ovf_s  = 1'b0;
        end else begin
            ovf_s = ovf_s;
        end
    end

    // State, counters and registered output decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            phase_r <= '0;
            pend_r  <= '0;
            ovf_r   <= 1'b0;
            led_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            pend_r  <= pend_s;
            ovf_r   <= ovf_s;
            led_r   <= (state_s == S_ON);
            busy_r  <= (state_s != S_IDLE);
        end
    end

    assign bus.o_led      = led_r;
    assign bus.o_busy     = busy_r;
    assign bus.o_pending  = pend_r;
    assign bus.o_overflow = ovf_r;
endmodule

// File: tb/tb_led_blink_queue.sv
// Directed bench for led_blink_queue at TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3, PEND_W=2.
// One blink is 8 cycles lit followed by 12 cycles dark.
module tb_led_blink_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    led_blink_queue_if #(.PEND_W(2)) bus ();

    led_blink_queue #(
        .TICK_DIV  (4),
        .ON_TICKS  (2),
        .OFF_TICKS (3),
        .PEND_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        bus.i_pulse = 1'b0;
        bus.i_clr   = 1'b0;
        rst         = 1'b1;
        #2;
        checks++;
        if ({bus.o_led, bus.o_busy, bus.o_pending, bus.o_overflow} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {bus.o_led, bus.o_busy, bus.o_pending, bus.o_overflow});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.o_led, bus.o_busy} !== 2'b00) begin
                failures++;
                $display("FAIL reset_idle k=%0d led/busy got=%b exp=00", k, {bus.o_led, bus.o_busy});
            end
        end
    endtask

    task automatic test_single();
        bus.i_pulse = 1'b1;
        @(negedge clk);
        bus.i_pulse = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            checks++;
            if (bus.o_led !== (k <= 8)) begin
                failures++;
                $display("FAIL single_led k=%0d got=%b exp=%b", k, bus.o_led, (k <= 8));
            end
            checks++;
            if (bus.o_busy !== (k <= 20)) begin
                failures++;
                $display("FAIL single_busy k=%0d got=%b exp=%b", k, bus.o_busy, (k <= 20));
            end
            checks++;
            if (bus.o_pending !== 2'd0) begin
                failures++;
                $display("FAIL single_pending k=%0d got=%0d exp=0", k, bus.o_pending);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_queue();
        logic       exp_led;
        logic [1:0] exp_pend;
        bus.i_pulse = 1'b1;
        @(negedge clk);
        bus.i_pulse = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            exp_led  = (k <= 8) || (k >= 21 && k <= 28) || (k >= 41 && k <= 48);
            exp_pend = (k < 3) ? 2'd0 : (k < 6) ? 2'd1 : (k < 21) ? 2'd2 : (k < 41) ? 2'd1 : 2'd0;
            checks++;
            if (bus.o_led !== exp_led) begin
                failures++;
                $display("FAIL queue_led k=%0d got=%b exp=%b", k, bus.o_led, exp_led);
            end
            checks++;
            if (bus.o_pending !== exp_pend) begin
                failures++;
                $display("FAIL queue_pending k=%0d got=%0d exp=%0d", k, bus.o_pending, exp_pend);
            end
            checks++;
            if (bus.o_busy !== (k <= 60)) begin
                failures++;
                $display("FAIL queue_busy k=%0d got=%b exp=%b", k, bus.o_busy, (k <= 60));
            end
            bus.i_pulse = (k == 2) || (k == 5);
            @(negedge clk);
        end
        bus.i_pulse = 1'b0;
    endtask

    task automatic test_overflow_clear();
        logic [1:0] exp_pend;
        bus.i_pulse = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 22; k++) begin
            exp_pend = (k < 2) ? 2'd0 : (k == 2) ? 2'd1 : (k == 3) ? 2'd2 : (k <= 5) ? 2'd3 : 2'd0;
            checks++;
            if (bus.o_pending !== exp_pend) begin
                failures++;
                $display("FAIL ovf_pending k=%0d got=%0d exp=%0d", k, bus.o_pending, exp_pend);
            end
            checks++;
            if (bus.o_overflow !== (k == 5)) begin
                failures++;
                $display("FAIL ovf_flag k=%0d got=%b exp=%b", k, bus.o_overflow, (k == 5));
            end
            checks++;
            if ({bus.o_led, bus.o_busy} !== {(k <= 8), (k <= 20)}) begin
                failures++;
                $display("FAIL ovf_blink k=%0d led/busy got=%b exp=%b", k,
                         {bus.o_led, bus.o_busy}, {(k <= 8), (k <= 20)});
            end
            bus.i_pulse = (k <= 4);
            bus.i_clr   = (k == 5);
            @(negedge clk);
        end
        bus.i_pulse = 1'b0;
        bus.i_clr   = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_led;
        bus.i_pulse = 1'b1;
        @(negedge clk);
        bus.i_pulse = 1'b0;
        for (int k = 1; k <= 42; k++) begin
            exp_led = (k <= 8) || (k >= 21 && k <= 28);
            checks++;
            if (bus.o_led !== exp_led) begin
                failures++;
                $display("FAIL b2b_led k=%0d got=%b exp=%b", k, bus.o_led, exp_led);
            end
            checks++;
            if (bus.o_busy !== (k <= 40)) begin
                failures++;
                $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, bus.o_busy, (k <= 40));
            end
            checks++;
            if (bus.o_pending !== 2'd0) begin
                failures++;
                $display("FAIL b2b_pending k=%0d got=%0d exp=0", k, bus.o_pending);
            end
            bus.i_pulse = (k == 20);
            @(negedge clk);
        end
        bus.i_pulse = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.i_pulse = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.i_pulse = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_led, bus.o_busy, bus.o_pending} !== 4'b1110) begin
            failures++;
            $display("FAIL arst_before got=%b exp=1110", {bus.o_led, bus.o_busy, bus.o_pending});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_led, bus.o_busy, bus.o_pending, bus.o_overflow} !== 5'b00000) begin
            failures++;
            $display("FAIL arst_immediate got=%b exp=00000",
                     {bus.o_led, bus.o_busy, bus.o_pending, bus.o_overflow});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue();
        test_overflow_clear();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
